// File: rtl/ibuf_ctrl_decoder_pkg.sv
// Shared opcode/funct constants and the control bundle carried
// with every buffered instruction.
package ibuf_ctrl_decoder_pkg;

    localparam int CTRL_W = 19;

    // Field order fixes the out_ctrl bit positions, regwrite = bit 18.
    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic       alusrc;
        logic       branch;
        logic       memtoreg;
        logic       jump;
        logic       is_imm;
        logic [1:0] hilo_en;
        logic       mov_write;
        logic       mov_read;
        logic       is_muldiv;
        logic       mem_signed;
        logic [3:0] mem_we_bhw;
        logic       illegal;
        logic       is_al;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_J      = 6'b000010;
    localparam logic [5:0] OP_JAL    = 6'b000011;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;
    localparam logic [5:0] OP_ADDI   = 6'b001000;
    localparam logic [5:0] OP_ADDIU  = 6'b001001;
    localparam logic [5:0] OP_SLTI   = 6'b001010;
    localparam logic [5:0] OP_SLTIU  = 6'b001011;
    localparam logic [5:0] OP_ANDI   = 6'b001100;
    localparam logic [5:0] OP_ORI    = 6'b001101;
    localparam logic [5:0] OP_XORI   = 6'b001110;
    localparam logic [5:0] OP_LUI    = 6'b001111;
    localparam logic [5:0] OP_LB     = 6'b100000;
    localparam logic [5:0] OP_LH     = 6'b100001;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_LBU    = 6'b100100;
    localparam logic [5:0] OP_LHU    = 6'b100101;
    localparam logic [5:0] OP_SB     = 6'b101000;
    localparam logic [5:0] OP_SH     = 6'b101001;
    localparam logic [5:0] OP_SW     = 6'b101011;

    localparam logic [5:0] FUNC_SLL   = 6'b000000;
    localparam logic [5:0] FUNC_SRL   = 6'b000010;
    localparam logic [5:0] FUNC_SRA   = 6'b000011;
    localparam logic [5:0] FUNC_SLLV  = 6'b000100;
    localparam logic [5:0] FUNC_SRLV  = 6'b000110;
    localparam logic [5:0] FUNC_SRAV  = 6'b000111;
    localparam logic [5:0] FUNC_JR    = 6'b001000;
    localparam logic [5:0] FUNC_JALR  = 6'b001001;
    localparam logic [5:0] FUNC_MFHI  = 6'b010000;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MFLO  = 6'b010010;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;
    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_ADD   = 6'b100000;
    localparam logic [5:0] FUNC_ADDU  = 6'b100001;
    localparam logic [5:0] FUNC_SUB   = 6'b100010;
    localparam logic [5:0] FUNC_SUBU  = 6'b100011;
    localparam logic [5:0] FUNC_AND   = 6'b100100;
    localparam logic [5:0] FUNC_OR    = 6'b100101;
    localparam logic [5:0] FUNC_XOR   = 6'b100110;
    localparam logic [5:0] FUNC_NOR   = 6'b100111;
    localparam logic [5:0] FUNC_SLT   = 6'b101010;
    localparam logic [5:0] FUNC_SLTU  = 6'b101011;

    localparam logic [4:0] RT_BLTZ   = 5'b00000;
    localparam logic [4:0] RT_BGEZ   = 5'b00001;
    localparam logic [4:0] RT_BLTZAL = 5'b10000;
    localparam logic [4:0] RT_BGEZAL = 5'b10001;

    // mem_signed idles high so only LBU/LHU have to clear it.
    function automatic ctrl_t ctrl_nop();
        ctrl_t c;
        c = '0;
        c.mem_signed = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/ibuf_ctrl_decoder_if.sv
// Fetch-side push and decode-side pop handshakes of the
// instruction buffer.
interface ibuf_ctrl_decoder_if #(
    parameter int PC_W = 32
);
    import ibuf_ctrl_decoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_instr;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic [PC_W-1:0]   out_pc;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_ctrl
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_ctrl
    );

endinterface

// File: rtl/ibuf_ctrl_decoder_inst_ctrl_dec.sv
// Combinational MIPS main decoder: instruction word to control
// bundle, with illegal-instruction detection.
module ibuf_ctrl_decoder_inst_ctrl_dec
    import ibuf_ctrl_decoder_pkg::*;
#(
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic [31:0] i_instr,
    output ctrl_t       o_ctrl
);

    logic [5:0] w_op;
    logic [4:0] w_rt;
    logic [5:0] w_fn;
    logic       w_ill;
    ctrl_t      w_c;

    assign w_op = i_instr[31:26];
    assign w_rt = i_instr[20:16];
    assign w_fn = i_instr[5:0];

    always_comb begin
        w_c   = ctrl_nop();
        w_ill = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_fn)
                    FUNC_SLL, FUNC_SRL, FUNC_SRA,
                    FUNC_SLLV, FUNC_SRLV, FUNC_SRAV,
                    FUNC_ADD, FUNC_ADDU, FUNC_SUB, FUNC_SUBU,
                    FUNC_AND, FUNC_OR, FUNC_XOR, FUNC_NOR,
                    FUNC_SLT, FUNC_SLTU: begin
                        w_c.regwrite = 1'b1;
                        w_c.regdst   = 1'b1;
                    end
                    FUNC_JR: w_c.jump = 1'b1;
                    FUNC_JALR: begin
                        w_c.regwrite = 1'b1;
                        w_c.regdst   = 1'b1;
                        w_c.jump     = 1'b1;
                        w_c.is_al    = 1'b1;
                    end
                    FUNC_MFHI, FUNC_MFLO: begin
                        w_c.regwrite = 1'b1;
                        w_c.regdst   = 1'b1;
                        w_c.mov_read = 1'b1;
                        w_c.hilo_en  = w_fn[1] ? 2'b01 : 2'b10;
                        w_ill        = !ENABLE_MULDIV;
                    end
                    FUNC_MTHI, FUNC_MTLO: begin
                        w_c.mov_write = 1'b1;
                        w_c.hilo_en   = w_fn[1] ? 2'b01 : 2'b10;
                        w_ill         = !ENABLE_MULDIV;
                    end
                    FUNC_MULT, FUNC_MULTU,
                    FUNC_DIV, FUNC_DIVU: begin
                        w_c.hilo_en   = 2'b11;
                        w_c.is_muldiv = 1'b1;
                        w_ill         = !ENABLE_MULDIV;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_REGIMM: begin
                case (w_rt)
                    RT_BLTZ, RT_BGEZ, RT_BLTZAL, RT_BGEZAL: begin
                        w_c.branch   = 1'b1;
                        w_c.regwrite = w_rt[4];
                        w_c.is_al    = w_rt[4];
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_J: w_c.jump = 1'b1;
            OP_JAL: begin
                w_c.jump     = 1'b1;
                w_c.regwrite = 1'b1;
                w_c.is_al    = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: w_c.branch = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                w_c.regwrite = 1'b1;
                w_c.alusrc   = 1'b1;
                w_c.is_imm   = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
                w_c.regwrite = 1'b1;
                w_c.alusrc   = 1'b1;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                w_c.regwrite   = 1'b1;
                w_c.alusrc     = 1'b1;
                w_c.memtoreg   = 1'b1;
                w_c.mem_signed = !(w_op == OP_LBU || w_op == OP_LHU);
                w_c.mem_we_bhw = (w_op == OP_LW) ? 4'b0001 :
                                 w_op[0]         ? 4'b0010 : 4'b0100;
            end
            OP_SB, OP_SH, OP_SW: begin
                w_c.alusrc     = 1'b1;
                w_c.mem_we_bhw = (w_op == OP_SW) ? 4'b1001 :
                                 w_op[0]         ? 4'b1010 : 4'b1100;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_c         = ctrl_nop();
            w_c.illegal = 1'b1;
        end
    end

    assign o_ctrl = w_c;

endmodule

// File: rtl/ibuf_ctrl_decoder.sv
// Instruction FIFO between fetch and decode; each entry is decoded
// on enqueue and stored as {instr, pc, ctrl}.
module ibuf_ctrl_decoder
    import ibuf_ctrl_decoder_pkg::*;
#(
    parameter int DEPTH         = 4,
    parameter int PC_W          = 32,
    parameter bit ENABLE_MULDIV = 1'b1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    ibuf_ctrl_decoder_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;
    logic [31:0]     r_instr [DEPTH];
    logic [PC_W-1:0] r_pc    [DEPTH];
    ctrl_t           r_ctrl  [DEPTH];

    logic  w_full;
    logic  w_empty;
    logic  w_push;
    logic  w_pop;
    ctrl_t w_dec;

    ibuf_ctrl_decoder_inst_ctrl_dec #(
        .ENABLE_MULDIV(ENABLE_MULDIV)
    ) u_dec (
        .i_instr(bus.in_instr),
        .o_ctrl (w_dec)
    );

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid & ~w_full & ~flush;
    assign w_pop   = ~w_empty & bus.out_ready & ~flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wptr] <= bus.in_instr;
            r_pc[r_wptr]    <= bus.in_pc;
            r_ctrl[r_wptr]  <= w_dec;
        end
    end

    assign bus.in_ready  = ~w_full;
    assign bus.out_valid = ~w_empty;
    assign bus.out_instr = w_empty ? '0 : r_instr[r_rptr];
    assign bus.out_pc    = w_empty ? '0 : r_pc[r_rptr];
    assign bus.out_ctrl  = w_empty ? '0 : r_ctrl[r_rptr];
    assign count         = r_count;

endmodule

// File: tb/tb_ibuf_ctrl_decoder.sv
// Directed self-checking bench for ibuf_ctrl_decoder, with a second
// instance built without mul/div support.
module tb_ibuf_ctrl_decoder;

    logic       clk;
    logic       resetn;
    logic       flush;
    logic [2:0] count;
    logic [2:0] count0;
    int         checks;
    int         errors;

    ibuf_ctrl_decoder_if #(.PC_W(32)) bus ();
    ibuf_ctrl_decoder_if #(.PC_W(32)) bus0 ();

    ibuf_ctrl_decoder #(
        .DEPTH(4), .PC_W(32), .ENABLE_MULDIV(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .bus(bus.slave), .count(count)
    );

    ibuf_ctrl_decoder #(
        .DEPTH(4), .PC_W(32), .ENABLE_MULDIV(1'b0)
    ) dut0 (
        .clk(clk), .resetn(resetn), .flush(flush),
        .bus(bus0.slave), .count(count0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0",
                     bus.in_ready, bus.out_valid);
        end
        checks++;
        if (count !== 3'd0 || bus.out_ctrl !== 19'h0 || bus.out_instr !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: count=%0d ctrl=%h instr=%h want 0/0/0",
                     count, bus.out_ctrl, bus.out_instr);
        end
    endtask

    task automatic test_addi();
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h20080005;
        bus.in_pc    = 32'hBFC00000;
        cyc();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b1 || count !== 3'd1) begin
            errors++;
            $display("FAIL addi_valid: out_valid=%b count=%0d want 1/1",
                     bus.out_valid, count);
        end
        checks++;
        if (bus.out_ctrl !== 19'h50040) begin
            errors++;
            $display("FAIL addi_ctrl: got %h want %h", bus.out_ctrl, 19'h50040);
        end
        checks++;
        if (bus.out_pc !== 32'hBFC00000 || bus.out_instr !== 32'h20080005) begin
            errors++;
            $display("FAIL addi_payload: pc=%h instr=%h want bfc00000/20080005",
                     bus.out_pc, bus.out_instr);
        end
        bus.out_ready = 1'b1;
        cyc();
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL addi_pop: count=%0d out_valid=%b want 0/0",
                     count, bus.out_valid);
        end
    endtask

    task automatic test_mem_seq();
        logic [31:0] w [3];
        logic [18:0] e [3];
        w = '{32'h8C880004, 32'hA0880000, 32'h04100003};
        e = '{19'h54044, 19'h10070, 19'h48041};
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = w[i];
            bus.in_pc    = 32'h1000 + 32'(i * 4);
            cyc();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL mem_count: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.out_ctrl !== e[i] || bus.out_instr !== w[i]) begin
                errors++;
                $display("FAIL mem_seq[%0d]: ctrl=%h instr=%h want %h/%h",
                         i, bus.out_ctrl, bus.out_instr, e[i], w[i]);
            end
            bus.out_ready = 1'b1;
            cyc();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_muldiv();
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00850018;
        bus0.in_valid = 1'b1;
        bus0.in_instr = 32'h00850018;
        cyc();
        bus.in_valid  = 1'b0;
        bus0.in_valid = 1'b0;
        checks++;
        if (bus.out_ctrl !== 19'h00CC0) begin
            errors++;
            $display("FAIL mult_en: got %h want %h", bus.out_ctrl, 19'h00CC0);
        end
        checks++;
        if (bus0.out_ctrl !== 19'h00042 || count0 !== 3'd1) begin
            errors++;
            $display("FAIL mult_dis: ctrl=%h count=%0d want 00042/1",
                     bus0.out_ctrl, count0);
        end
        bus.out_ready  = 1'b1;
        bus0.out_ready = 1'b1;
        cyc();
        bus.out_ready  = 1'b0;
        bus0.out_ready = 1'b0;
    endtask

    task automatic test_decode();
        logic [31:0] w [6];
        logic [18:0] e [6];
        w = '{32'h0000F809, 32'h90880000, 32'h3C08FFFF,
              32'hFC000000, 32'h01095021, 32'h04020000};
        e = '{19'h62041, 19'h54010, 19'h51040,
              19'h00042, 19'h60040, 19'h00042};
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = w[i];
            cyc();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_ctrl !== e[i]) begin
                errors++;
                $display("FAIL decode[%0d] %h: got %h want %h",
                         i, w[i], bus.out_ctrl, e[i]);
            end
            bus.out_ready = 1'b1;
            cyc();
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q [$];
        logic [31:0] nxt;
        int          guard;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h20080000 + 32'(i);
            q.push_back(32'h20080000 + 32'(i));
            cyc();
        end
        checks++;
        if (count !== 3'd4 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full: count=%0d in_ready=%b want 4/0",
                     count, bus.in_ready);
        end
        bus.in_instr = 32'hDEAD0000;
        cyc();
        checks++;
        if (count !== 3'd4 || bus.out_instr !== 32'h20080000) begin
            errors++;
            $display("FAIL overflow: count=%0d head=%h want 4/20080000",
                     count, bus.out_instr);
        end
        nxt = 32'h20090000;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus.in_instr = nxt;
            checks++;
            if (bus.out_instr !== q[0] || bus.in_ready !== (q.size() < 4)) begin
                errors++;
                $display("FAIL b2b[%0d]: head=%h in_ready=%b want %h/%b",
                         k, bus.out_instr, bus.in_ready, q[0], q.size() < 4);
            end
            if (q.size() < 4) begin
                q.push_back(nxt);
                nxt = nxt + 1;
            end
            void'(q.pop_front());
            cyc();
        end
        bus.in_valid = 1'b0;
        guard = 0;
        while (q.size() > 0 && guard < 8) begin
            checks++;
            if (bus.out_instr !== q[0]) begin
                errors++;
                $display("FAIL drain: head=%h want %h", bus.out_instr, q[0]);
            end
            void'(q.pop_front());
            guard++;
            cyc();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || q.size() != 0) begin
            errors++;
            $display("FAIL drain_end: count=%0d left=%0d want 0/0",
                     count, q.size());
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h20080010 + 32'(i);
            cyc();
        end
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL flush_fill: got %0d want 3", count);
        end
        flush        = 1'b1;
        bus.in_instr = 32'h240A0007;
        cyc();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush: count=%0d out_valid=%b in_ready=%b want 0/0/1",
                     count, bus.out_valid, bus.in_ready);
        end
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin
            errors++;
            $display("FAIL flush_drop: out_valid=%b instr=%h want 0/0",
                     bus.out_valid, bus.out_instr);
        end
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        checks++;
        if (count !== 3'd0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_empty: count=%0d in_ready=%b want 0/1",
                     count, bus.in_ready);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 2; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = 32'h20080020 + 32'(i);
            cyc();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL areset_fill: got %0d want 2", count);
        end
        #3;
        resetn = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL areset: in_ready=%b out_valid=%b count=%0d want 1/0/0",
                     bus.in_ready, bus.out_valid, count);
        end
        #2;
        resetn = 1'b1;
        cyc();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin
            errors++;
            $display("FAIL areset_after: out_valid=%b instr=%h want 0/0",
                     bus.out_valid, bus.out_instr);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1, "timeout");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        resetn         = 1'b0;
        flush          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_instr   = '0;
        bus.in_pc      = '0;
        bus.out_ready  = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_instr  = '0;
        bus0.in_pc     = '0;
        bus0.out_ready = 1'b0;
        repeat (2) cyc();
        test_reset();
        resetn = 1'b1;
        cyc();
        test_addi();
        test_mem_seq();
        test_muldiv();
        test_decode();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
